// File: rtl/multi_edge_counter_pkg.sv
// multi_edge_counter_pkg
// Shared definitions for the multi-channel edge counter:
//   - edge_mode encodings
//   - legal parameter ranges
//   - byte extraction helper used by the output mux
package multi_edge_counter_pkg;

    typedef enum logic [1:0] {
        EM_BOTH  = 2'b00,   // count rising and falling edges
        EM_RISE  = 2'b01,   // count rising edges only
        EM_FALL  = 2'b10,   // count falling edges only
        EM_LEVEL = 2'b11    // count clock cycles while the input is high
    } edge_mode_e;

    localparam int NCH_MIN  = 1;
    localparam int NCH_MAX  = 8;
    localparam int CW_MIN   = 8;
    localparam int CW_MAX   = 32;
    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 3;

    // Width of the zero-extended word the output mux slices bytes from.
    localparam int WORD_W   = 32;

    // Pick one byte of a 32-bit word; sel = 0 is bits 7:0.
    function automatic logic [7:0] byte_of(input logic [WORD_W-1:0] word,
                                           input logic [1:0]        sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/multi_edge_counter_edge_ch.sv
// edge_ch
// One counting channel: input synchronizer, delay flop, edge/level detect,
// saturating-or-wrapping counter, sticky overflow flag and snapshot register.
// Ports:
//   clk25      in   clock, rising edge
//   rst        in   synchronous active-high reset (counter, snapshot, ovf)
//   sig        in   asynchronous signal to count
//   edge_mode  in   2-bit event selection (see edge_mode_e)
//   pause      in   1 = hold the counter
//   sat_en     in   1 = saturate at all-ones, 0 = wrap to zero
//   snap_pulse in   single-cycle capture strobe for the snapshot
//   count      out  live counter value
//   snapshot   out  last captured counter value
//   ovf        out  sticky overflow flag
module edge_ch
    import multi_edge_counter_pkg::*;
#(
    parameter int CW          = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk25,
    input  logic          rst,
    input  logic          sig,
    input  logic [1:0]    edge_mode,
    input  logic          pause,
    input  logic          sat_en,
    input  logic          snap_pulse,
    output logic [CW-1:0] count,
    output logic [CW-1:0] snapshot,
    output logic          ovf
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   delay_r;
    logic                   sync_last_s;
    logic                   event_s;
    logic [CW-1:0]          count_r;
    logic [CW-1:0]          count_nxt_s;
    logic [CW-1:0]          snapshot_r;
    logic                   ovf_r;
    logic                   ovf_nxt_s;

    assign sync_last_s = sync_r[SYNC_STAGES-1];

    // Synchronizer chain and delay flop; deliberately not reset so the chain
    // already holds the live input level when reset is released.
    always_ff @(posedge clk25) begin
        sync_r  <= {sync_r[SYNC_STAGES-2:0], sig};
        delay_r <= sync_last_s;
    end

    // Event detect: compare the synchronized level with its one-cycle-old copy.
    always_comb begin
        event_s = 1'b0;
        case (edge_mode)
            EM_BOTH:  event_s = sync_last_s ^ delay_r;
            EM_RISE:  event_s = sync_last_s & ~delay_r;
            EM_FALL:  event_s = ~sync_last_s & delay_r;
            EM_LEVEL: event_s = sync_last_s;
            default:  event_s = 1'b0;
        endcase
    end

    // Next counter / overflow value; an increment at all-ones always flags ovf.
    always_comb begin
        count_nxt_s = count_r;
        ovf_nxt_s   = ovf_r;
        if (!pause && event_s) begin
            if (count_r == CNT_MAX) begin
                count_nxt_s = sat_en ? CNT_MAX : {CW{1'b0}};
                ovf_nxt_s   = 1'b1;
            end else begin
                count_nxt_s = count_r + CNT_ONE;
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Counter, sticky overflow and snapshot; the snapshot takes the value the
    // counter held before any increment happening in the same cycle.
    always_ff @(posedge clk25) begin
        if (rst) begin
            count_r    <= {CW{1'b0}};
            snapshot_r <= {CW{1'b0}};
            ovf_r      <= 1'b0;
        end else begin
            count_r    <= count_nxt_s;
            ovf_r      <= ovf_nxt_s;
            snapshot_r <= snap_pulse ? count_r : snapshot_r;
        end
    end

    assign count    = count_r;
    assign snapshot = snapshot_r;
    assign ovf      = ovf_r;

endmodule

// File: rtl/multi_edge_counter.sv
// multi_edge_counter
// NCH independent edge/level counters with a common snapshot strobe and a
// byte-wide read-back mux.
// Ports:
//   clk25      in   clock, rising edge
//   rst        in   synchronous active-high reset
//   sig_in     in   NCH asynchronous signals to count
//   edge_mode  in   00 both edges, 01 rising, 10 falling, 11 high-level cycles
//   pause      in   1 = freeze all counters
//   sat_en     in   1 = saturate at max, 0 = wrap
//   snap       in   rising edge captures all counters into snapshots
//   src_live   in   1 = read live counters, 0 = read snapshots
//   ch_sel     in   channel select
//   byte_sel   in   byte select, 0 = bits 7:0
//   out_byte   out  selected byte (combinational from registers)
//   ovf        out  sticky per-channel overflow flags
module multi_edge_counter
    import multi_edge_counter_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int CW          = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                   clk25,
    input  logic                                   rst,
    input  logic [NCH-1:0]                         sig_in,
    input  logic [1:0]                             edge_mode,
    input  logic                                   pause,
    input  logic                                   sat_en,
    input  logic                                   snap,
    input  logic                                   src_live,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] ch_sel,
    input  logic [1:0]                             byte_sel,
    output logic [7:0]                             out_byte,
    output logic [NCH-1:0]                         ovf
);

    localparam int CSW  = (NCH > 1) ? $clog2(NCH) : 1;
    // Every ch_sel code gets a mux entry; codes beyond NCH read zero.
    localparam int NSEL = 1 << CSW;

    if (NCH < NCH_MIN || NCH > NCH_MAX) begin : g_bad_nch
        $error("multi_edge_counter: NCH out of range");
    end
    if (CW < CW_MIN || CW > CW_MAX) begin : g_bad_cw
        $error("multi_edge_counter: CW out of range");
    end
    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
        $error("multi_edge_counter: SYNC_STAGES out of range");
    end

    logic                snap_prev_r;
    logic                snap_pulse_s;
    logic [CW-1:0]       count_s    [NCH];
    logic [CW-1:0]       snapshot_s [NCH];
    logic [WORD_W-1:0]   word_s     [NSEL];

    assign snap_pulse_s = snap & ~snap_prev_r;

    // Previous snap level for rising-edge detection of the snapshot strobe.
    always_ff @(posedge clk25) begin
        if (rst) begin
            snap_prev_r <= 1'b0;
        end else begin
            snap_prev_r <= snap;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        edge_ch #(
            .CW          (CW),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk25      (clk25),
            .rst        (rst),
            .sig        (sig_in[i]),
            .edge_mode  (edge_mode),
            .pause      (pause),
            .sat_en     (sat_en),
            .snap_pulse (snap_pulse_s),
            .count      (count_s[i]),
            .snapshot   (snapshot_s[i]),
            .ovf        (ovf[i])
        );
    end

    // Zero-extend each channel's selected source; bits above CW-1 read 0.
    for (genvar j = 0; j < NSEL; j++) begin : g_word
        if (j < NCH) begin : g_real
            assign word_s[j] = WORD_W'(src_live ? count_s[j] : snapshot_s[j]);
        end else begin : g_pad
            assign word_s[j] = {WORD_W{1'b0}};
        end
    end

    assign out_byte = byte_of(word_s[ch_sel], byte_sel);

endmodule

// File: tb/tb_multi_edge_counter.sv
// tb_multi_edge_counter
// Self-checking bench: a cycle-level reference model of the counters runs
// beside the main instance (NCH=4, CW=24, SYNC_STAGES=2) and is compared on
// every falling edge; directed scenarios pin known literal results, and a
// small second instance (NCH=3, CW=8, SYNC_STAGES=3) exercises overflow,
// saturation, wrap and out-of-range selects.
module tb_multi_edge_counter;
    import multi_edge_counter_pkg::*;

    localparam int NCH  = 4;
    localparam int CW   = 24;
    localparam int SS   = 2;
    localparam int NCH8 = 3;
    localparam int CW8  = 8;
    localparam int SS8  = 3;
    localparam longint MAXV = (longint'(1) << CW) - 1;

    logic             clk25 = 1'b0;
    logic             rst;
    logic [NCH-1:0]   sig_in;
    logic [1:0]       edge_mode;
    logic             pause, sat_en, snap, src_live;
    logic [1:0]       ch_sel;
    logic [1:0]       byte_sel;
    logic [7:0]       out_byte;
    logic [NCH-1:0]   ovf;
    logic [NCH8-1:0]  sig8;
    logic [1:0]       ch_sel8;
    logic [7:0]       out_byte8;
    logic [NCH8-1:0]  ovf8;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #20 clk25 = ~clk25;

    multi_edge_counter #(.NCH(NCH), .CW(CW), .SYNC_STAGES(SS)) dut (
        .clk25(clk25), .rst(rst), .sig_in(sig_in), .edge_mode(edge_mode),
        .pause(pause), .sat_en(sat_en), .snap(snap), .src_live(src_live),
        .ch_sel(ch_sel), .byte_sel(byte_sel), .out_byte(out_byte), .ovf(ovf)
    );

    multi_edge_counter #(.NCH(NCH8), .CW(CW8), .SYNC_STAGES(SS8)) dut8 (
        .clk25(clk25), .rst(rst), .sig_in(sig8), .edge_mode(edge_mode),
        .pause(pause), .sat_en(sat_en), .snap(snap), .src_live(src_live),
        .ch_sel(ch_sel8), .byte_sel(byte_sel), .out_byte(out_byte8), .ovf(ovf8)
    );

    // ---------------- reference model ----------------
    // Input seen by the detector at edge n is the sample taken at edge n-SS,
    // compared against the sample from edge n-SS-1.
    longint         mcnt  [NCH];
    longint         msnap [NCH];
    bit             movf  [NCH];
    bit             mprev_snap;
    logic [NCH-1:0] hist [$];
    logic [NCH-1:0] cur_v, old_v;
    bit             ev;

    initial begin
        for (int i = 0; i <= SS; i++) hist.push_back('0);
        for (int i = 0; i < NCH; i++) begin
            mcnt[i] = 0; msnap[i] = 0; movf[i] = 1'b0;
        end
        mprev_snap = 1'b0;
    end

    always @(posedge clk25) begin
        cur_v = hist[1];
        old_v = hist[0];
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                mcnt[i] = 0; msnap[i] = 0; movf[i] = 1'b0;
            end
            mprev_snap = 1'b0;
        end else begin
            if (snap && !mprev_snap)
                for (int i = 0; i < NCH; i++) msnap[i] = mcnt[i];
            for (int i = 0; i < NCH; i++) begin
                case (edge_mode)
                    2'b00:   ev = (cur_v[i] != old_v[i]);
                    2'b01:   ev = cur_v[i] && !old_v[i];
                    2'b10:   ev = !cur_v[i] && old_v[i];
                    default: ev = cur_v[i];
                endcase
                if (!pause && ev) begin
                    if (mcnt[i] == MAXV) begin
                        movf[i] = 1'b1;
                        mcnt[i] = sat_en ? MAXV : 0;
                    end else begin
                        mcnt[i] = mcnt[i] + 1;
                    end
                end
            end
            mprev_snap = snap;
        end
        hist.push_back(sig_in);
        hist.delete(0);
    end

    function automatic longint exp_out();
        longint w;
        w = src_live ? mcnt[ch_sel] : msnap[ch_sel];
        return (w >> (8 * int'(byte_sel))) & 255;
    endfunction

    function automatic longint exp_ovf();
        longint v = 0;
        for (int i = 0; i < NCH; i++) if (movf[i]) v = v | (longint'(1) << i);
        return v;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk25) begin
        if (chk_en) begin
            check("cyc_out_byte", longint'(out_byte), exp_out());
            check("cyc_ovf", longint'(ovf), exp_ovf());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk25);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic expect_main(input string name, input logic [1:0] c,
                               input logic [1:0] b, input logic l, input longint exp);
        ch_sel = c; byte_sel = b; src_live = l;
        #1;
        check(name, longint'(out_byte), exp);
    endtask

    task automatic expect_8(input string name, input logic [1:0] c,
                            input logic [1:0] b, input longint exp);
        ch_sel8 = c; byte_sel = b; src_live = 1'b1;
        #1;
        check(name, longint'(out_byte8), exp);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        rst = 1'b1; sig_in = '0; edge_mode = EM_BOTH; pause = 1'b0; sat_en = 1'b0;
        snap = 1'b0; src_live = 1'b1; ch_sel = 2'd0; byte_sel = 2'd0;
        sig8 = '0; ch_sel8 = 2'd0;
        repeat (2) tick();
        chk_en = 1'b1;
        do_reset(3);

        // Reset state
        for (int c = 0; c < NCH; c++) begin
            expect_main("reset_live", 2'(c), 2'd0, 1'b1, 0);
            expect_main("reset_snap", 2'(c), 2'd0, 1'b0, 0);
        end
        check("reset_ovf", longint'(ovf), 0);

        // Both-edge mode: 10 toggles on channel 1, plus first-increment latency
        edge_mode = EM_BOTH; ch_sel = 2'd1; byte_sel = 2'd0; src_live = 1'b1;
        sig_in[1] = 1'b1;
        tick(); tick();
        expect_main("latency_edge2", 2'd1, 2'd0, 1'b1, 0);
        tick();
        expect_main("latency_edge3", 2'd1, 2'd0, 1'b1, 1);
        for (int k = 1; k < 10; k++) begin
            sig_in[1] = ~sig_in[1];
            tick(); tick();
        end
        repeat (4) tick();
        expect_main("both_ch1", 2'd1, 2'd0, 1'b1, 8'h0A);
        check("both_model_ch1", mcnt[1], 10);
        expect_main("both_ch0", 2'd0, 2'd0, 1'b1, 0);
        expect_main("both_ch2", 2'd2, 2'd0, 1'b1, 0);
        expect_main("both_ch3", 2'd3, 2'd0, 1'b1, 0);

        // Level mode: 37 high cycles, then again with 10 paused cycles
        do_reset(4);
        edge_mode = EM_LEVEL;
        sig_in[2] = 1'b1;
        repeat (37) tick();
        sig_in[2] = 1'b0;
        repeat (4) tick();
        expect_main("level_37", 2'd2, 2'd0, 1'b1, 8'h25);
        check("level_model_37", mcnt[2], 37);
        do_reset(4);
        sig_in[2] = 1'b1;
        repeat (15) tick();
        pause = 1'b1;
        repeat (10) tick();
        pause = 1'b0;
        repeat (12) tick();
        sig_in[2] = 1'b0;
        repeat (4) tick();
        expect_main("level_paused", 2'd2, 2'd0, 1'b1, 8'h1B);
        check("level_model_paused", mcnt[2], 27);

        // Snapshot coinciding with an increment at count 0x102, then 5 more
        do_reset(4);
        edge_mode = EM_LEVEL;
        for (int n = 1; n <= 266; n++) begin
            snap      = (n == 261);
            sig_in[0] = (n <= 264);
            tick();
        end
        snap = 1'b0;
        repeat (4) tick();
        expect_main("snap_b0", 2'd0, 2'd0, 1'b0, 8'h02);
        expect_main("snap_b1", 2'd0, 2'd1, 1'b0, 8'h01);
        expect_main("snap_b2", 2'd0, 2'd2, 1'b0, 8'h00);
        expect_main("live_b0", 2'd0, 2'd0, 1'b1, 8'h08);
        expect_main("live_b1", 2'd0, 2'd1, 1'b1, 8'h01);
        expect_main("live_b2", 2'd0, 2'd2, 1'b1, 8'h00);
        expect_main("live_b3", 2'd0, 2'd3, 1'b1, 8'h00);
        check("snap_model", msnap[0], 258);

        // Mid-count reset with sig_in[3] held high through release
        do_reset(4);
        edge_mode = EM_RISE;
        for (int k = 0; k < 3; k++) begin
            sig_in[3] = 1'b1; tick(); tick();
            sig_in[3] = 1'b0; tick(); tick();
        end
        repeat (3) tick();
        snap = 1'b1; tick(); snap = 1'b0;
        expect_main("pre_rst_ch3", 2'd3, 2'd0, 1'b1, 3);
        expect_main("pre_rst_snap3", 2'd3, 2'd0, 1'b0, 3);
        sig_in[3] = 1'b1;
        tick();
        do_reset(3);
        for (int c = 0; c < NCH; c++) begin
            expect_main("post_rst_live", 2'(c), 2'd0, 1'b1, 0);
            expect_main("post_rst_snap", 2'(c), 2'd0, 1'b0, 0);
        end
        check("post_rst_ovf", longint'(ovf), 0);
        repeat (5) tick();
        expect_main("post_rst_nocount", 2'd3, 2'd0, 1'b1, 0);
        sig_in[3] = 1'b0;

        // 8-bit instance: SYNC_STAGES=3 latency, saturation, wrap, ovf
        do_reset(5);
        edge_mode = EM_RISE; sat_en = 1'b0;
        sig8[0] = 1'b1;
        repeat (3) tick();
        expect_8("c8_latency_edge3", 2'd0, 2'd0, 0);
        tick();
        expect_8("c8_latency_edge4", 2'd0, 2'd0, 1);
        for (int k = 1; k < 255; k++) begin
            sig8[0] = 1'b0; tick();
            sig8[0] = 1'b1; tick();
        end
        repeat (6) tick();
        expect_8("c8_full", 2'd0, 2'd0, 8'hFF);
        check("c8_full_ovf", longint'(ovf8), 0);
        expect_8("c8_chsel_oob", 2'd3, 2'd0, 0);
        expect_8("c8_above_cw", 2'd0, 2'd1, 0);
        sat_en = 1'b1;
        sig8[0] = 1'b0; tick(); tick();
        sig8[0] = 1'b1; repeat (6) tick();
        expect_8("c8_saturate", 2'd0, 2'd0, 8'hFF);
        check("c8_sat_ovf", longint'(ovf8), 1);
        sat_en = 1'b0;
        sig8[0] = 1'b0; tick(); tick();
        sig8[0] = 1'b1; repeat (6) tick();
        expect_8("c8_wrap", 2'd0, 2'd0, 8'h00);
        check("c8_wrap_ovf", longint'(ovf8), 1);

        // Randomized traffic checked every cycle against the model
        do_reset(4);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 2) == 0) sig_in = NCH'($urandom());
            if ($urandom_range(0, 63) == 0) edge_mode = 2'($urandom());
            if ($urandom_range(0, 127) == 0) sat_en = ~sat_en;
            pause    = ($urandom_range(0, 9) == 0);
            snap     = ($urandom_range(0, 7) == 0);
            src_live = 1'($urandom());
            ch_sel   = 2'($urandom());
            byte_sel = ($urandom_range(0, 3) == 0) ? 2'd1 : 2'd0;
            if (!rst && $urandom_range(0, 399) == 0) rst = 1'b1;
            else if (rst && $urandom_range(0, 2) == 0) rst = 1'b0;
            tick();
        end
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
